dot_matrix_scanner: RTL and testbench

Parametrised row-scanning driver for an LED dot-matrix display, successor to the fixed 8x8 three-image driver. Holds a writable multi-frame bitmap buffer, scans one row per `div_clk` tick, switches displayed frame only at frame boundaries (tear-free), and supports blanking. It sits between the top-level mode/state logic and the board's dot-matrix row/column pins, clocked from the scan clock divider.

---
 rtl/dot_matrix_scanner_pkg.sv | 50 +++++
 rtl/dot_matrix_scanner_if.sv | 48 ++++
 rtl/dot_matrix_scanner_frame_buffer.sv | 56 +++++
 rtl/dot_matrix_scanner.sv | 132 +++++++++++++
 tb/tb_dot_matrix_scanner.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dot_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dot_matrix_pkg
// Description : Shared helpers for the dot-matrix scanner: row-select
//               pattern generation, column rotate-left and dimension
//               limits. Functions work on a fixed 16-bit container; callers
//               size-cast the result to their own ROWS/COLS width.
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
package dot_matrix_pkg;

    localparam int unsigned c_MAX_DIM = 16;  // largest supported ROWS/COLS
    localparam int unsigned c_IDX_W   = 4;   // index width covering c_MAX_DIM

    // Select pattern for row idx: row r lives at bit rows-1-r. With
    // active_low the pattern is one-cold instead of one-hot.
    function automatic logic [c_MAX_DIM-1:0] row_sel(
        input logic [c_IDX_W-1:0] idx,
        input int                 rows,
        input logic               active_low
    );
        logic [c_MAX_DIM-1:0] v;
        v = '0;
        for (int i = 0; i < int'(c_MAX_DIM); i++) begin
            if (i == rows - 1 - int'(idx)) begin
                v[i] = 1'b1;
            end
        end
        return active_low ? ~v : v;
    endfunction

    // Rotate the low `width` bits of d left by amt (amt < width).
    // Bits above `width` in the result are forced to zero.
    function automatic logic [c_MAX_DIM-1:0] rotl(
        input logic [c_MAX_DIM-1:0] d,
        input int                   width,
        input logic [c_IDX_W-1:0]   amt
    );
        logic [2*c_MAX_DIM-1:0] w;
        logic [2*c_MAX_DIM-1:0] mask;
        w    = ({{c_MAX_DIM{1'b0}}, d} << amt)
             | ({{c_MAX_DIM{1'b0}}, d} >> (width - int'(amt)));
        mask = (32'd1 << width) - 32'd1;
        w    = w & mask;
        return w[c_MAX_DIM-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_matrix_scanner_if
// Description : Control/bitmap-write inputs and row/column outputs of the
//               dot-matrix scanner.
//               master : frame_sel, blank, wr_* (and scroll_en) out;
//                        dot_row, dot_col, frame_done in.
//               slave  : the reverse (scanner side).
// Macros      : DOT_SCROLL_EN adds scroll_en.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_matrix_scanner_if
    import dot_matrix_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int FRAMES = 4
);
    localparam int c_FW = $clog2(FRAMES);
    localparam int c_RW = $clog2(ROWS);

    logic [c_FW-1:0] frame_sel;
    logic            blank;
    logic            wr_en;
    logic [c_FW-1:0] wr_frame;
    logic [c_RW-1:0] wr_row;
    logic [COLS-1:0] wr_data;
`ifdef DOT_SCROLL_EN
    logic            scroll_en;
`endif
    logic [ROWS-1:0] dot_row;
    logic [COLS-1:0] dot_col;
    logic            frame_done;

`ifdef DOT_SCROLL_EN
    modport master (output frame_sel, blank, wr_en, wr_frame, wr_row, wr_data, scroll_en,
                    input  dot_row, dot_col, frame_done);
    modport slave  (input  frame_sel, blank, wr_en, wr_frame, wr_row, wr_data, scroll_en,
                    output dot_row, dot_col, frame_done);
`else
    modport master (output frame_sel, blank, wr_en, wr_frame, wr_row, wr_data,
                    input  dot_row, dot_col, frame_done);
    modport slave  (input  frame_sel, blank, wr_en, wr_frame, wr_row, wr_data,
                    output dot_row, dot_col, frame_done);
`endif

endinterface
`default_nettype wire

// File: rtl/dot_matrix_scanner_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dot_frame_buffer
// Description : FRAMES x ROWS x COLS bitmap store. One synchronous write
//               port, one combinational read port. A read of the entry being
//               written on the same edge returns the old contents.
// Ports       : clk_i, rst_i (async, active-high, clears the array)
//               wr_en_i/wr_frame_i/wr_row_i/wr_data_i - write port
//               rd_frame_i/rd_row_i -> rd_data_o       - read port
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
module dot_frame_buffer
    import dot_matrix_pkg::*;
#(
    parameter  int ROWS   = 8,
    parameter  int COLS   = 8,
    parameter  int FRAMES = 4,
    localparam int c_FW   = $clog2(FRAMES),
    localparam int c_RW   = $clog2(ROWS)
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            wr_en_i,
    input  wire logic [c_FW-1:0] wr_frame_i,
    input  wire logic [c_RW-1:0] wr_row_i,
    input  wire logic [COLS-1:0] wr_data_i,
    input  wire logic [c_FW-1:0] rd_frame_i,
    input  wire logic [c_RW-1:0] rd_row_i,
    output logic      [COLS-1:0] rd_data_o
);
    // One extra bit so ROWS itself is representable in the compare.
    localparam logic [c_RW:0] c_ROWS_EXT = (c_RW+1)'(ROWS);

    logic [COLS-1:0] mem_q [FRAMES][ROWS];
    logic            w_row_ok;

    // Row codes past ROWS-1 exist when ROWS is not a power of two; drop them.
    assign w_row_ok = ({1'b0, wr_row_i} < c_ROWS_EXT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int f = 0; f < FRAMES; f++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[f][r] <= '0;
                end
            end
        end else if (wr_en_i && w_row_ok) begin
            mem_q[wr_frame_i][wr_row_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_frame_i][rd_row_i];

endmodule
`default_nettype wire

// File: rtl/dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : dot_matrix_scanner
// Description : Row-scanning LED dot-matrix driver. One row per div_clk
//               edge, frame selection latched only at the frame wrap so a
//               frame is never torn, blanking keeps the scan running.
// Ports       : div_clk, reset (async assert, active-high)
//               bus (slave) - frame_sel, blank, bitmap write port in;
//                             dot_row, dot_col, frame_done out.
// Macros      : DOT_SCROLL_EN - horizontal scroll: column data rotated left
//               by an offset that steps every SCROLL_DIV-th frame boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_matrix_scanner
    import dot_matrix_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int FRAMES         = 4,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter int SCROLL_DIV     = 16
) (
    input wire logic             div_clk,
    input wire logic             reset,
    dot_matrix_scanner_if.slave  bus
);
    localparam int              c_FW       = $clog2(FRAMES);
    localparam int              c_RW       = $clog2(ROWS);
    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(ROWS - 1);
    localparam logic [ROWS-1:0] c_ROW_IDLE = ROW_ACTIVE_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};

    // Out-of-range configurations elaborate this empty block; kept so a
    // netlist review can spot a bad parameter set.
    if (ROWS < 2 || ROWS > 16 || COLS < 2 || COLS > 16 || FRAMES < 2 ||
        (FRAMES & (FRAMES - 1)) != 0 || SCROLL_DIV < 1) begin : g_cfg_out_of_range
    end

    logic [c_RW-1:0] row_count_q,    row_count_d;
    logic [c_FW-1:0] active_frame_q, active_frame_d;
    logic [ROWS-1:0] dot_row_q,      dot_row_d;
    logic [COLS-1:0] dot_col_q,      dot_col_d;
    logic            frame_done_q,   frame_done_d;

    logic            w_wrap;
    logic [ROWS-1:0] w_sel;
    logic [COLS-1:0] w_fetch;
    logic [COLS-1:0] w_col;

    dot_frame_buffer #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .FRAMES (FRAMES)
    ) u_buf (
        .clk_i      (div_clk),
        .rst_i      (reset),
        .wr_en_i    (bus.wr_en),
        .wr_frame_i (bus.wr_frame),
        .wr_row_i   (bus.wr_row),
        .wr_data_i  (bus.wr_data),
        .rd_frame_i (active_frame_q),
        .rd_row_i   (row_count_q),
        .rd_data_o  (w_fetch)
    );

    assign w_wrap = (row_count_q == c_LAST_ROW);
    assign w_sel  = ROWS'(row_sel(c_IDX_W'(row_count_q), ROWS, ROW_ACTIVE_LOW));

`ifdef DOT_SCROLL_EN
    logic [c_IDX_W-1:0]   offset_q,  offset_d;
    logic [c_MAX_DIM-1:0] div_cnt_q, div_cnt_d;

    assign w_col = COLS'(rotl(c_MAX_DIM'(w_fetch), COLS, offset_q));

    // Offset moves on the wrap edge, the same edge that latches the frame,
    // so every frame is shown at a single offset.
    always_comb begin
        offset_d  = offset_q;
        div_cnt_d = div_cnt_q;
        if (w_wrap && bus.scroll_en) begin
            if (div_cnt_q == c_MAX_DIM'(SCROLL_DIV - 1)) begin
                div_cnt_d = '0;
                offset_d  = (offset_q == c_IDX_W'(COLS - 1)) ? '0 : offset_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            offset_q  <= '0;
            div_cnt_q <= '0;
        end else begin
            offset_q  <= offset_d;
            div_cnt_q <= div_cnt_d;
        end
    end
`else
    assign w_col = w_fetch;
`endif

    always_comb begin
        row_count_d    = w_wrap ? '0 : row_count_q + 1'b1;
        active_frame_d = w_wrap ? bus.frame_sel : active_frame_q;
        dot_row_d      = bus.blank ? c_ROW_IDLE : w_sel;
        dot_col_d      = bus.blank ? '0 : w_col;
        // Pulses with the last row even when blanked, keeping frame timing.
        frame_done_d   = w_wrap;
    end

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            row_count_q    <= '0;
            active_frame_q <= '0;
            dot_row_q      <= c_ROW_IDLE;
            dot_col_q      <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            row_count_q    <= row_count_d;
            active_frame_q <= active_frame_d;
            dot_row_q      <= dot_row_d;
            dot_col_q      <= dot_col_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign bus.dot_row    = dot_row_q;
    assign bus.dot_col    = dot_col_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_matrix_scanner
// Description : Self-checking bench for dot_matrix_scanner (8x8, 4 frames,
//               active-low rows). Table of per-cycle vectors plus directed
//               sequences for async reset and, with DOT_SCROLL_EN, scrolling.
// Macros      : DOT_SCROLL_EN - also exercises the scroll offset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_matrix_scanner;
    import dot_matrix_pkg::*;

`ifdef DOT_SCROLL_EN
    localparam int c_SDIV = 1;
`else
    localparam int c_SDIV = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_matrix_scanner_if #(.ROWS(8), .COLS(8), .FRAMES(4)) bus ();

    dot_matrix_scanner #(
        .ROWS           (8),
        .COLS           (8),
        .FRAMES         (4),
        .ROW_ACTIVE_LOW (1'b1),
        .SCROLL_DIV     (c_SDIV)
    ) dut (
        .div_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    typedef struct {
        logic       blank;
        logic       wr_en;
        logic [1:0] wr_frame;
        logic [2:0] wr_row;
        logic [7:0] wr_data;
        logic [1:0] frame_sel;
        logic [7:0] exp_row;
        logic [7:0] exp_col;
        logic       exp_done;
    } vec_t;

    localparam int NV = 48;
    vec_t vecs [NV];

    logic [7:0] rowpat [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] d0     [8] = '{8'h0C, 8'h0C, 8'h19, 8'h7E, 8'h98, 8'h18, 8'h28, 8'h48};
    logic [7:0] f1     [8] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    endtask

    task automatic check_out(input string tag, input int idx, input logic [7:0] er,
                             input logic [7:0] ec, input logic ed);
        check({tag, ".dot_row"},    idx, 16'(bus.dot_row),    16'(er));
        check({tag, ".dot_col"},    idx, 16'(bus.dot_col),    16'(ec));
        check({tag, ".frame_done"}, idx, 16'(bus.frame_done), 16'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int k, input logic bl, input logic we, input logic [1:0] wf,
                           input logic [2:0] wrw, input logic [7:0] wd, input logic [1:0] fs,
                           input logic [7:0] er, input logic [7:0] ec, input logic ed);
        vecs[k] = '{bl, we, wf, wrw, wd, fs, er, ec, ed};
    endtask

    task automatic idle_inputs();
        bus.blank    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_frame = '0;
        bus.wr_row   = '0;
        bus.wr_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        bus.frame_sel = '0;
`ifdef DOT_SCROLL_EN
        bus.scroll_en = 1'b0;
`endif

        for (int i = 0; i < 8; i++) begin
            // pass A: load frame 0; each write hits the row being read -> old (0) shown
            set_vec(i,      1'b0, 1'b1, 2'd0, 3'(i), d0[i], 2'd0, rowpat[i], 8'h00, i == 7);
            // pass B: frame 0 displayed
            set_vec(8 + i,  1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 2'd0, rowpat[i], d0[i], i == 7);
            // pass C: load frame 1 in background
            set_vec(16 + i, 1'b0, 1'b1, 2'd1, 3'(i), f1[i], 2'd0, rowpat[i], d0[i], i == 7);
            // pass D: frame_sel -> 1 from row 3; whole pass stays on frame 0
            set_vec(24 + i, 1'b0, 1'b0, 2'd0, 3'd0, 8'h00, (i >= 3) ? 2'd1 : 2'd0,
                    rowpat[i], d0[i], i == 7);
            // pass E: frame 1; row 2 rewritten to FF on its own read edge; rows 5..7 blanked
            set_vec(32 + i, (i >= 5), (i == 2), 2'd1, 3'd2, 8'hFF, 2'd1,
                    (i >= 5) ? 8'hFF : rowpat[i], (i >= 5) ? 8'h00 : f1[i], i == 7);
            // pass F: new row 2 data visible
            set_vec(40 + i, 1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 2'd1, rowpat[i],
                    (i == 2) ? 8'hFF : f1[i], i == 7);
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, 8'hFF, 8'h00, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.blank     = vecs[i].blank;
            bus.wr_en     = vecs[i].wr_en;
            bus.wr_frame  = vecs[i].wr_frame;
            bus.wr_row    = vecs[i].wr_row;
            bus.wr_data   = vecs[i].wr_data;
            bus.frame_sel = vecs[i].frame_sel;
            step();
            check_out("vec", i, vecs[i].exp_row, vecs[i].exp_col, vecs[i].exp_done);
        end
        idle_inputs();

        // async reset mid-frame: outputs go idle without a clock edge
        repeat (3) step();
        #3;
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 8'hFF, 8'h00, 1'b0);
        step();
        rst = 1'b0;

        // after reset frame 0 is shown although frame_sel=1; frame 1 from next wrap
        bus.wr_en = 1'b1; bus.wr_frame = 2'd0; bus.wr_row = 3'd1; bus.wr_data = 8'h11;
        step();
        check_out("post_rst", 0, 8'h7F, 8'h00, 1'b0);
        bus.wr_frame = 2'd1; bus.wr_row = 3'd0; bus.wr_data = 8'h22;
        step();
        check_out("post_rst", 1, 8'hBF, 8'h11, 1'b0);
        idle_inputs();
        for (int i = 2; i < 8; i++) begin
            step();
            check_out("post_rst", i, rowpat[i], 8'h00, i == 7);
        end
        step();
        check_out("post_rst", 8, 8'h7F, 8'h22, 1'b0);

`ifdef DOT_SCROLL_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.frame_sel = 2'd0;
        bus.wr_en = 1'b1; bus.wr_frame = 2'd0; bus.wr_row = 3'd0; bus.wr_data = 8'h80;
        step();
        idle_inputs();
        repeat (7) step();
        step();
        check("scroll.row0", 0, 16'(bus.dot_col), 16'h0080);
        bus.scroll_en = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            repeat (8) step();
            check("scroll.row0", p, 16'(bus.dot_col), 16'(8'h01 << (p - 1)));
        end
        step();
        #3;
        rst = 1'b1;
        #1;
        check_out("scroll_rst", 0, 8'hFF, 8'h00, 1'b0);
        step();
        rst = 1'b0;
        bus.scroll_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_frame = 2'd0; bus.wr_row = 3'd0; bus.wr_data = 8'h80;
        step();
        idle_inputs();
        repeat (8) step();
        check("scroll.offset0", 0, 16'(bus.dot_col), 16'h0080);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
